// File: rtl/dlx_pkg.sv
// Shared definitions for the DLX pipeline memory stage.
// Holds the access-size codes, the memory-stage FSM encoding and the
// byte-enable lane patterns. It also holds the packed EX/MEM bundle and an
// alignment helper used by mem_stage.
// Byte lanes are big-endian: the leftmost byte-enable bit selects the most
// significant data byte, bits [31:24].
package dlx_pkg;

   // Access size codes carried in DSize (1x = word)
   localparam logic [1:0] DSIZE_BYTE = 2'b00;
   localparam logic [1:0] DSIZE_HALF = 2'b01;
   localparam logic [1:0] DSIZE_WORD = 2'b10;

   // Memory-stage FSM encoding
   localparam logic STATE_IDLE = 1'b0;
   localparam logic STATE_WAIT = 1'b1;

   // Byte-enable lane patterns
   localparam logic [3:0] BE_BYTE0   = 4'b1000;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_WORD    = 4'b1111;

   // EX/MEM pipeline register contents; an all-zero value is a bubble
   typedef struct packed {
      logic        valid;
      logic [31:0] aluResult;
      logic [31:0] storeData;
      logic [31:0] nextPC;
      logic [31:0] leapAddr;
      logic        leap;
      logic [4:0]  destReg;
      logic        pcToReg;
      logic        regWrite;
      logic        memToReg;
      logic        memWrite;
      logic        loadSign;
      logic [1:0]  dSize;
   } exMemBundle;

   // Bytes are always aligned, halves need an even address and words need
   // both low address bits clear
   function automatic logic isAligned(input logic [1:0] dSize, input logic [1:0] lowAddr);
      logic ok;
      case (dSize)
         DSIZE_BYTE: ok = 1'b1;
         DSIZE_HALF: ok = ~lowAddr[0];
         default:    ok = (lowAddr == 2'b00);
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_align.sv
// Data-memory lane steering for the memory stage (purely combinational).
// Ports:
//   byteAddr   - low two address bits of the access
//   dSize      - access size code (byte, half or word)
//   loadSign   - 1 = sign-extend loaded byte/half, 0 = zero-extend
//   storeData  - register operand to be stored
//   loadData   - raw word returned by data memory
//   byteEnable - big-endian lane enables (leftmost bit = bits [31:24])
//   writeData  - store operand replicated across all lanes
//   readValue  - selected load lane, right-justified and extended
import dlx_pkg::*;

module mem_align (
   input  logic [1:0]  byteAddr,
   input  logic [1:0]  dSize,
   input  logic        loadSign,
   input  logic [31:0] storeData,
   input  logic [31:0] loadData,
   output logic [3:0]  byteEnable,
   output logic [31:0] writeData,
   output logic [31:0] readValue
);

   logic [7:0]  laneByte;
   logic [15:0] laneHalf;

   // Pick the addressed byte and half out of the big-endian load word
   always_comb begin
      laneByte = loadData[31:24];
      case (byteAddr)
         2'b00:   laneByte = loadData[31:24];
         2'b01:   laneByte = loadData[23:16];
         2'b10:   laneByte = loadData[15:8];
         default: laneByte = loadData[7:0];
      endcase
      laneHalf = byteAddr[1] ? loadData[15:0] : loadData[31:16];
   end

   // Lane enables, replicated store data and the extended load value by size
   always_comb begin
      byteEnable = BE_WORD;
      writeData  = storeData;
      readValue  = loadData;
      case (dSize)
         DSIZE_BYTE: begin
            byteEnable = BE_BYTE0 >> byteAddr;
            writeData  = {4{storeData[7:0]}};
            readValue  = loadSign ? {{24{laneByte[7]}}, laneByte} : {24'd0, laneByte};
         end
         DSIZE_HALF: begin
            byteEnable = byteAddr[1] ? BE_HALF_LO : BE_HALF_HI;
            writeData  = {2{storeData[15:0]}};
            readValue  = loadSign ? {{16{laneHalf[15]}}, laneHalf} : {16'd0, laneHalf};
         end
         default: begin
            byteEnable = BE_WORD;
            writeData  = storeData;
            readValue  = loadData;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage DLX pipeline.
// It latches the EX result bundle and performs loads and stores over a
// variable-latency req/ack data port. It stalls upstream while an access is
// outstanding, then registers the MEM/WB bundle and the branch/jump redirect.
// Ports:
//   clk, reset             - clock and asynchronous active-low reset
//   ex_valid, *_in         - EX-stage result bundle and control bits
//   dmem_*                 - data-memory request/acknowledge port
//   stall                  - freezes PC, IF/ID and ID/EX
//   leap_out, leapAddr_out - registered redirect to fetch
//   wb_valid .. RegWrite_out - MEM/WB bundle
//   misalign_err, bus_err  - single-cycle error pulses on the completion cycle
// Parameter TIMEOUT (2..255) is the number of cycles in WAIT before the
// access is abandoned with bus_err.
import dlx_pkg::*;

module mem_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic [31:0] aluResult_in,
   input  logic [31:0] storeData_in,
   input  logic [31:0] nextPC_in,
   input  logic [31:0] leapAddr_in,
   input  logic        leap_in,
   input  logic [4:0]  destReg_in,
   input  logic        PCtoReg_in,
   input  logic        RegWrite_in,
   input  logic        MemToReg_in,
   input  logic        MemWrite_in,
   input  logic        loadSign_in,
   input  logic [1:0]  DSize_in,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        stall,
   output logic        leap_out,
   output logic [31:0] leapAddr_out,
   output logic        wb_valid,
   output logic [31:0] wbData_out,
   output logic [4:0]  destReg_out,
   output logic        RegWrite_out,
   output logic        misalign_err,
   output logic        bus_err
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   exMemBundle  m;
   logic        state;
   logic [7:0]  cnt;
   logic        needAccess;
   logic        misaligned;
   logic        reqActive;
   logic        timedOut;
   logic        complete;
   logic [3:0]  alignBe;
   logic [31:0] alignWdata;
   logic [31:0] loadValue;

   mem_align uAlign (
      .byteAddr   (m.aluResult[1:0]),
      .dSize      (m.dSize),
      .loadSign   (m.loadSign),
      .storeData  (m.storeData),
      .loadData   (dmem_rdata),
      .byteEnable (alignBe),
      .writeData  (alignWdata),
      .readValue  (loadValue)
   );

   // Decide whether the held instruction touches memory and whether it
   // finishes this cycle. A misaligned access finishes at once without ever
   // requesting. An ack arriving with no request outstanding is ignored.
   // Because M is frozen while stalled, the request fields stay stable
   // throughout WAIT.
   always_comb begin
      needAccess = m.valid & (m.memToReg | m.memWrite) & ~m.leap;
      misaligned = needAccess & ~isAligned(m.dSize, m.aluResult[1:0]);
      reqActive  = needAccess & ~misaligned;
      timedOut   = reqActive & (state == STATE_WAIT) & (cnt == TIMEOUT_LAST) & ~dmem_ack;
      complete   = misaligned | (reqActive & (dmem_ack | timedOut));
      stall      = needAccess & ~complete;
   end

   // Drive the data-memory port only while a real request is outstanding
   always_comb begin
      dmem_req     = reqActive;
      dmem_we      = reqActive & m.memWrite;
      dmem_addr    = reqActive ? {m.aluResult[31:2], 2'b00} : 32'd0;
      dmem_be      = reqActive ? alignBe : 4'd0;
      dmem_wdata   = reqActive ? alignWdata : 32'd0;
      misalign_err = misaligned;
      bus_err      = timedOut;
   end

   // EX/MEM register: advances whenever the stage is not stalled.
   // A bubble from EX is stored as all-zero controls.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m <= '0;
      end else if (!stall) begin
         if (ex_valid) begin
            m <= '{valid: 1'b1, aluResult: aluResult_in, storeData: storeData_in,
                   nextPC: nextPC_in, leapAddr: leapAddr_in, leap: leap_in,
                   destReg: destReg_in, pcToReg: PCtoReg_in, regWrite: RegWrite_in,
                   memToReg: MemToReg_in, memWrite: MemWrite_in, loadSign: loadSign_in,
                   dSize: DSize_in};
         end else begin
            m <= '0;
         end
      end
   end

   // Access FSM: IDLE issues the request; if it is not acknowledged at once
   // we sit in WAIT counting cycles until ack or the timeout gives up
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= STATE_IDLE;
         cnt   <= 8'd0;
      end else begin
         case (state)
            STATE_IDLE: begin
               if (reqActive && !dmem_ack) begin
                  state <= STATE_WAIT;
                  cnt   <= 8'd0;
               end
            end
            default: begin
               if (complete || !reqActive) begin
                  state <= STATE_IDLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
         endcase
      end
   end

   // MEM/WB register and redirect. These are captured whenever the stage is
   // not stalled. While stalled, a bubble goes downstream so that write-back
   // never sees the same instruction twice. Errors suppress the register write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_valid     <= 1'b0;
         wbData_out   <= 32'd0;
         destReg_out  <= 5'd0;
         RegWrite_out <= 1'b0;
         leap_out     <= 1'b0;
         leapAddr_out <= 32'd0;
      end else if (stall) begin
         wb_valid     <= 1'b0;
         RegWrite_out <= 1'b0;
         leap_out     <= 1'b0;
      end else begin
         wb_valid     <= m.valid;
         destReg_out  <= m.destReg;
         RegWrite_out <= m.valid & m.regWrite & ~misaligned & ~timedOut;
         leap_out     <= m.valid & m.leap;
         leapAddr_out <= m.leapAddr;
         if (m.pcToReg) begin
            wbData_out <= m.nextPC;
         end else if (m.memToReg) begin
            wbData_out <= loadValue;
         end else begin
            wbData_out <= m.aluResult;
         end
      end
   end

endmodule
